// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: miss controller in front of the 2-way cache array.
// Serves CPU loads/stores one at a time. A miss writes back a dirty victim
// line word by word, refills the line from memory, then replays the access.
// Optional hit/miss/write-back counters: define CACHE_MISS_CTRL_STATS_EN.
module cache_miss_ctrl #(
  parameter int  OFFSET_WIDTH = 3,
  parameter int  INDEX_WIDTH  = 6,
  parameter int  TAG_WIDTH    = 30 - OFFSET_WIDTH - INDEX_WIDTH,
  localparam int BLOCK_SIZE   = 1 << OFFSET_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef CACHE_MISS_CTRL_STATS_EN
  output logic [31:0]             stat_hits,
  output logic [31:0]             stat_misses,
  output logic [31:0]             stat_wbs,
`endif
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [31:0]             cpu_addr,
  input  logic [31:0]             cpu_wdata,
  input  logic [3:0]              cpu_byte_en,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_ready,
  output logic                    c_enable,
  output logic                    c_cmp,
  output logic                    c_write,
  output logic                    c_valid_in,
  output logic [INDEX_WIDTH-1:0]  c_index,
  output logic [OFFSET_WIDTH-1:0] c_word_sel,
  output logic [TAG_WIDTH-1:0]    c_tag_in,
  output logic [31:0]             c_data_in,
  output logic [3:0]              c_byte_w_en,
  input  logic                    c_hit,
  input  logic                    c_dirty,
  input  logic                    c_valid_out,
  input  logic [TAG_WIDTH-1:0]    c_tag_out,
  input  logic [31:0]             c_data_out,
  input  logic [32*BLOCK_SIZE-1:0] c_data_wb,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_ack,
  input  logic [31:0]             mem_rdata
);

  typedef enum logic [2:0] {IDLE, COMPARE, VICTIM, WB, REFILL, DONE} state_t;

  state_t                   state, state_nxt;
  logic [TAG_WIDTH-1:0]     req_tag, victim_tag;
  logic [INDEX_WIDTH-1:0]   req_index;
  logic [OFFSET_WIDTH-1:0]  req_word, cnt;
  logic                     req_we;
  logic [31:0]              req_wdata;
  logic [3:0]               req_be;
  logic [32*BLOCK_SIZE-1:0] victim_buf;
  logic                     last_word, victim_dirty;

  assign last_word    = (cnt == {OFFSET_WIDTH{1'b1}});
  assign victim_dirty = c_dirty & c_valid_out;

  // State register, request latch, victim capture and burst word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_tag    <= '0;
      req_index  <= '0;
      req_word   <= '0;
      req_we     <= 1'b0;
      req_wdata  <= '0;
      req_be     <= '0;
      victim_tag <= '0;
      victim_buf <= '0;
      cnt        <= '0;
      cpu_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (cpu_req) begin
          req_tag   <= cpu_addr[31 -: TAG_WIDTH];
          req_index <= cpu_addr[OFFSET_WIDTH+2 +: INDEX_WIDTH];
          req_word  <= cpu_addr[2 +: OFFSET_WIDTH];
          req_we    <= cpu_we;
          req_wdata <= cpu_wdata;
          req_be    <= cpu_byte_en;
        end
        COMPARE: if (c_hit) cpu_rdata <= c_data_out;
        VICTIM: begin
          victim_tag <= c_tag_out;
          victim_buf <= c_data_wb;
          cnt        <= '0;
        end
        WB, REFILL: if (mem_ack) cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state logic and all array/memory/CPU handshake outputs.
  always_comb begin
    state_nxt   = state;
    cpu_ready   = 1'b0;
    c_enable    = 1'b0;
    c_cmp       = 1'b0;
    c_write     = 1'b0;
    c_valid_in  = 1'b0;
    c_index     = '0;
    c_word_sel  = '0;
    c_tag_in    = '0;
    c_data_in   = '0;
    c_byte_w_en = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (state)
      IDLE: if (cpu_req) state_nxt = COMPARE;
      COMPARE: begin
        c_enable   = 1'b1;
        c_cmp      = 1'b1;
        c_index    = req_index;
        c_word_sel = req_word;
        c_tag_in   = req_tag;
        if (req_we) begin
          // The array drops this write itself when the tag misses.
          c_write     = 1'b1;
          c_data_in   = req_wdata;
          c_byte_w_en = req_be;
          c_valid_in  = 1'b1;
        end
        state_nxt = c_hit ? DONE : VICTIM;
      end
      VICTIM: begin
        c_enable  = 1'b1;
        c_index   = req_index;
        state_nxt = victim_dirty ? WB : REFILL;
      end
      WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {victim_tag, req_index, cnt, 2'b00};
        mem_wdata = victim_buf[32*cnt +: 32];
        if (mem_ack && last_word) state_nxt = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_index, cnt, 2'b00};
        c_index  = req_index;
        if (mem_ack) begin
          // Refill word goes straight into the array in the ack cycle.
          c_enable    = 1'b1;
          c_write     = 1'b1;
          c_word_sel  = cnt;
          c_tag_in    = req_tag;
          c_data_in   = mem_rdata;
          c_byte_w_en = 4'hF;
          c_valid_in  = 1'b1;
          if (last_word) state_nxt = COMPARE;
        end
      end
      DONE: begin
        cpu_ready = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CACHE_MISS_CTRL_STATS_EN
  logic replay;

  // Saturating hit/miss/write-back counters; the post-refill replay hit is not a hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      replay      <= 1'b0;
      stat_hits   <= '0;
      stat_misses <= '0;
      stat_wbs    <= '0;
    end else begin
      if (state == IDLE && cpu_req) replay <= 1'b0;
      if (state == REFILL && mem_ack && last_word) replay <= 1'b1;
      if (state == COMPARE && c_hit && !replay && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
      if (state == COMPARE && !c_hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
      if (state == VICTIM && victim_dirty && stat_wbs != '1) stat_wbs <= stat_wbs + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Bench for cache_miss_ctrl: behavioural direct-mapped array and a stalling
// memory responder; expected CPU results and memory transfers are queued by
// the stimulus and checked by a separate monitor.
module tb_cache_miss_ctrl;
  localparam int OW = 3, IW = 6, TW = 21, BS = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]  cpu_byte_en = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic c_enable, c_cmp, c_write, c_valid_in;
  logic [IW-1:0] c_index;
  logic [OW-1:0] c_word_sel;
  logic [TW-1:0] c_tag_in, c_tag_out;
  logic [31:0]   c_data_in, c_data_out;
  logic [3:0]    c_byte_w_en;
  logic c_hit, c_dirty, c_valid_out;
  logic [32*BS-1:0] c_data_wb;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  cache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_byte_en(cpu_byte_en), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .c_enable(c_enable), .c_cmp(c_cmp), .c_write(c_write), .c_valid_in(c_valid_in),
    .c_index(c_index), .c_word_sel(c_word_sel), .c_tag_in(c_tag_in), .c_data_in(c_data_in),
    .c_byte_w_en(c_byte_w_en), .c_hit(c_hit), .c_dirty(c_dirty), .c_valid_out(c_valid_out),
    .c_tag_out(c_tag_out), .c_data_out(c_data_out), .c_data_wb(c_data_wb),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- cache array model (one way per set is enough here)
  logic          cv [64];
  logic          cd [64];
  logic [TW-1:0] ct [64];
  logic [31:0]   cdat [64][BS];
  logic          pl_en = 1'b0, pl_clr = 1'b0, pl_dirty = 1'b0;
  logic [5:0]    pl_set = '0;
  logic [TW-1:0] pl_tag = '0;
  logic [31:0]   pl_data [BS];

  assign c_hit       = c_enable & c_cmp & cv[c_index] & (ct[c_index] == c_tag_in);
  assign c_dirty     = cd[c_index];
  assign c_valid_out = cv[c_index];
  assign c_tag_out   = ct[c_index];
  assign c_data_out  = cdat[c_index][c_word_sel];

  always_comb begin
    c_data_wb = '0;
    for (int w = 0; w < BS; w++) c_data_wb[32*w +: 32] = cdat[c_index][w];
  end

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int s = 0; s < 64; s++) begin
        cv[s] = 1'b0; cd[s] = 1'b0; ct[s] = '0;
        for (int w = 0; w < BS; w++) cdat[s][w] = '0;
      end
    end else if (pl_en) begin
      cv[pl_set] = 1'b1; cd[pl_set] = pl_dirty; ct[pl_set] = pl_tag;
      for (int w = 0; w < BS; w++) cdat[pl_set][w] = pl_data[w];
    end else if (c_enable && c_write) begin
      if (c_cmp) begin
        if (c_hit) begin
          for (int b = 0; b < 4; b++)
            if (c_byte_w_en[b]) cdat[c_index][c_word_sel][8*b +: 8] = c_data_in[8*b +: 8];
          cd[c_index] = 1'b1;
          cv[c_index] = c_valid_in;
        end
      end else begin
        for (int b = 0; b < 4; b++)
          if (c_byte_w_en[b]) cdat[c_index][c_word_sel][8*b +: 8] = c_data_in[8*b +: 8];
        ct[c_index] = c_tag_in;
        cv[c_index] = c_valid_in;
        cd[c_index] = 1'b0;
      end
    end
  end

  // ---------------- memory responder with 0-3 cycle stalls between acks
  logic [31:0] mem_init [logic [31:0]];
  int stall = 0, pat_i = 0;
  int pat [6] = '{0, 1, 3, 2, 0, 2};
  initial begin mem_ack = 1'b0; mem_rdata = '0; end

  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!rst && mem_req) begin
      if (stall > 0) stall--;
      else begin
        mem_ack = 1'b1;
        if (!mem_we)
          mem_rdata = mem_init.exists(mem_addr) ? mem_init[mem_addr] : 32'h100 + {29'd0, mem_addr[4:2]};
        pat_i = (pat_i + 1) % 6;
        stall = pat[pat_i];
      end
    end
  end

  // ---------------- scoreboard
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } mem_t;
  typedef struct { logic chk; logic [31:0] data; } cpu_t;
  mem_t exp_mem[$];
  cpu_t exp_cpu[$];
  int n_vec = 0, n_bad = 0, wb_acks = 0;
  logic mem_seen = 1'b0;

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  function automatic logic [31:0] mk(input logic [TW-1:0] t, input logic [5:0] s, input logic [2:0] w);
    return {t, s, w, 2'b00};
  endfunction

  task automatic push_mem(input logic we, input logic [31:0] addr, input logic [31:0] data);
    mem_t m;
    m.we = we; m.addr = addr; m.data = data;
    exp_mem.push_back(m);
  endtask

  // Monitor: pops expectations whenever the DUT completes a transfer or a CPU access.
  logic        prev_wait = 1'b0, prev_we = 1'b0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;
  always @(negedge clk) begin
    mem_t em;
    cpu_t ec;
    #1;
    if (rst) prev_wait = 1'b0;
    else begin
      if (mem_req) mem_seen = 1'b1;
      if (prev_wait && mem_req) begin
        chk("hold_addr", mem_addr, prev_addr);
        if (prev_we) chk("hold_wdata", mem_wdata, prev_wdata);
      end
      if (mem_req && mem_ack) begin
        if (mem_we) wb_acks++;
        if (exp_mem.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_xfer: got addr %h we %0d, expected no transfer", mem_addr, mem_we);
        end else begin
          em = exp_mem.pop_front();
          chk("xfer_we", {31'd0, mem_we}, {31'd0, em.we});
          chk("xfer_addr", mem_addr, em.addr);
          if (em.we) chk("xfer_wdata", mem_wdata, em.data);
        end
      end
      prev_wait  = mem_req && !mem_ack;
      prev_we    = mem_we;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      if (cpu_ready) begin
        if (exp_cpu.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL unexpected_ready: got rdata %h, expected no completion", cpu_rdata);
        end else begin
          ec = exp_cpu.pop_front();
          if (ec.chk) chk("cpu_rdata", cpu_rdata, ec.data);
        end
      end
    end
  end

  // Issue one access and wait (bounded) for its completion pulse.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic chk_d, input logic [31:0] exp_d,
                        output int lat);
    cpu_t c;
    c.chk = chk_d; c.data = exp_d;
    exp_cpu.push_back(c);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_byte_en = be;
    lat = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      lat++;
      if (cpu_ready) break;
    end
    if (!cpu_ready) begin
      n_vec++; n_bad++;
      $display("FAIL req_timeout: got no cpu_ready after %0d cycles, expected completion", lat);
    end
    cpu_req = 1'b0;
  endtask

  task automatic preload(input logic [5:0] s, input logic [TW-1:0] t, input logic dirty, input logic [31:0] base);
    pl_set = s; pl_tag = t; pl_dirty = dirty;
    for (int w = 0; w < BS; w++) pl_data[w] = base + 32'(w);
    pl_en = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int lat;
    pl_clr = 1'b1;
    repeat (2) @(negedge clk);
    pl_clr = 1'b0;
    // reset state
    chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_c_ctrl", {28'd0, c_enable, c_cmp, c_write, c_valid_in}, 32'd0);
    chk("rst_c_tag_in", {11'd0, c_tag_in}, 32'd0);
    @(negedge clk) rst = 1'b0;

    // load hits
    preload(6'd5, 21'h1234, 1'b0, 32'h5A5A0000);
    pl_data[2] = 32'hDEADBEEF; pl_set = 6'd5; pl_en = 1'b1; @(negedge clk); pl_en = 1'b0;
    mem_seen = 1'b0;
    do_req(1'b0, mk(21'h1234, 6'd5, 3'd2), 32'd0, 4'h0, 1'b1, 32'hDEADBEEF, lat);
    chk("hit_latency", 32'(lat), 32'd2);
    do_req(1'b0, mk(21'h1234, 6'd5, 3'd6), 32'd0, 4'h0, 1'b1, 32'h5A5A0006, lat);
    chk("hit_no_mem", {31'd0, mem_seen}, 32'd0);

    // clean miss: refill only
    for (int i = 0; i < BS; i++) push_mem(1'b0, mk(21'h055, 6'd7, 3'(i)), 32'd0);
    do_req(1'b0, mk(21'h055, 6'd7, 3'd3), 32'd0, 4'h0, 1'b1, 32'h103, lat);
    chk("clean_burst_len", 32'(exp_mem.size()), 32'd0);

    // dirty miss: write-back then refill
    preload(6'd3, 21'h0AA, 1'b1, 32'hA0);
    for (int i = 0; i < BS; i++) push_mem(1'b1, mk(21'h0AA, 6'd3, 3'(i)), 32'hA0 + 32'(i));
    for (int i = 0; i < BS; i++) push_mem(1'b0, mk(21'h077, 6'd3, 3'(i)), 32'd0);
    do_req(1'b0, mk(21'h077, 6'd3, 3'd5), 32'd0, 4'h0, 1'b1, 32'h105, lat);
    chk("dirty_burst_len", 32'(exp_mem.size()), 32'd0);

    // store miss with partial byte enables, then load back
    mem_init[mk(21'h099, 6'd9, 3'd1)] = 32'hAABBCCDD;
    for (int i = 0; i < BS; i++) push_mem(1'b0, mk(21'h099, 6'd9, 3'(i)), 32'd0);
    do_req(1'b1, mk(21'h099, 6'd9, 3'd1), 32'h11223344, 4'b0011, 1'b0, 32'd0, lat);
    chk("store_burst_len", 32'(exp_mem.size()), 32'd0);
    mem_seen = 1'b0;
    do_req(1'b0, mk(21'h099, 6'd9, 3'd1), 32'd0, 4'h0, 1'b1, 32'hAABB3344, lat);
    chk("store_reload_no_mem", {31'd0, mem_seen}, 32'd0);

    // reset in the middle of a write-back burst
    for (int i = 0; i < BS; i++)
      push_mem(1'b1, mk(21'h099, 6'd9, 3'(i)), (i == 1) ? 32'hAABB3344 : 32'h100 + 32'(i));
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = mk(21'h042, 6'd9, 3'd0); wb_acks = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #2;
      if (wb_acks == 3) break;
    end
    chk("midwb_acks", 32'(wb_acks), 32'd3);
    rst = 1'b1;
    #1;
    chk("midwb_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midwb_mem_addr", mem_addr, 32'd0);
    chk("midwb_c_enable", {31'd0, c_enable}, 32'd0);
    chk("midwb_ready", {31'd0, cpu_ready}, 32'd0);
    cpu_req = 1'b0;
    exp_mem.delete();
    @(negedge clk) rst = 1'b0;

    // same request again: burst must restart at word 0
    for (int i = 0; i < BS; i++)
      push_mem(1'b1, mk(21'h099, 6'd9, 3'(i)), (i == 1) ? 32'hAABB3344 : 32'h100 + 32'(i));
    for (int i = 0; i < BS; i++) push_mem(1'b0, mk(21'h042, 6'd9, 3'(i)), 32'd0);
    do_req(1'b0, mk(21'h042, 6'd9, 3'd0), 32'd0, 4'h0, 1'b1, 32'h100, lat);
    chk("post_rst_burst_len", 32'(exp_mem.size()), 32'd0);

    repeat (5) @(negedge clk);
    chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
